// File: rtl/ctrl_reg_bridge_if.sv
// Core-side load/store request and response channel of the control-register bridge.
// The core drives the master modport and the bridge takes the slave modport.
interface ctrl_reg_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ctrl_reg_bridge.sv
// Front-end for the control-register scratch RAM: decodes and range-checks core requests,
// does read-modify-write for byte-strobed stores, and returns one response per request.
module ctrl_reg_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          NUM_WORDS   = 16,
  parameter int          RAM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  ctrl_reg_bridge_if.slave     bus,
  output logic                 ram_we,
  output logic [31:0]          ram_addr,
  output logic [31:0]          ram_din,
  input  logic [31:0]          ram_dout
);

  localparam int             CW        = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(RAM_LATENCY - 1);
  localparam logic [31:0]    WIN_BYTES = 32'(4 * NUM_WORDS);
  localparam logic [3:0]     IDX_MASK  = 4'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_RESP
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic          we_reg;
  logic          err_reg;
  logic [3:0]    wstrb_reg;
  logic [3:0]    addr_reg;
  logic [31:0]   din_reg;
  logic [31:0]   rdata_reg;
  logic [CW-1:0] cnt_reg;
  logic          ready_en_reg;

  logic          req_ready_c;
  logic          resp_valid_c;
  logic          ram_we_c;

  // ---------------------------------------------------------------- decode
  logic [31:0] off;
  logic        dec_err;
  logic [3:0]  dec_idx;
  logic        accept;
  logic        store_none;
  logic        store_full;
  logic        cnt_last;
  logic [31:0] merged;

  // Addresses below the base wrap to a huge offset and fail the window test.
  assign off        = bus.req_addr - BASE_ADDR;
  assign dec_err    = (bus.req_addr[1:0] != 2'b00) || (off >= WIN_BYTES);
  assign dec_idx    = off[5:2] & IDX_MASK;
  assign accept     = bus.req_valid && req_ready_c;
  assign store_none = bus.req_we && (bus.req_wstrb == 4'h0);
  assign store_full = bus.req_we && (bus.req_wstrb == 4'hF);
  assign cnt_last   = (cnt_reg == CNT_LAST);

  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged[8*gi +: 8] = wstrb_reg[gi] ? din_reg[8*gi +: 8] : ram_dout[8*gi +: 8];
  end

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (dec_err || store_none) begin
            state_next = ST_RESP;
          end else if (store_full) begin
            state_next = ST_WR;
          end else begin
            state_next = ST_RD;
          end
        end
      end
      ST_RD:   state_next = ST_WAIT;
      ST_WAIT: begin
        if (cnt_last) begin
          state_next = we_reg ? ST_WR : ST_RESP;
        end
      end
      ST_WR:   state_next = ST_RESP;
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  // ready_en_reg keeps req_ready low until the first edge after reset release.
  always_comb begin
    req_ready_c  = 1'b0;
    resp_valid_c = 1'b0;
    ram_we_c     = 1'b0;
    case (state_reg)
      ST_IDLE: req_ready_c  = ready_en_reg;
      ST_WR:   ram_we_c     = 1'b1;
      ST_RESP: resp_valid_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_c;
  assign bus.resp_rdata = rdata_reg;
  assign bus.resp_err   = err_reg;
  assign ram_we         = ram_we_c;
  assign ram_addr       = {28'd0, addr_reg};
  assign ram_din        = din_reg;

  // ---------------------------------------------------------------- datapath
  // din_reg holds the store data and is overwritten with the merged word on a
  // partial store, so WR always drives ram_din straight from it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_reg       <= 1'b0;
      err_reg      <= 1'b0;
      wstrb_reg    <= 4'h0;
      addr_reg     <= 4'h0;
      din_reg      <= 32'h0;
      rdata_reg    <= 32'h0;
      cnt_reg      <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (accept) begin
        we_reg    <= bus.req_we;
        err_reg   <= dec_err;
        wstrb_reg <= bus.req_wstrb;
        rdata_reg <= 32'h0;
        cnt_reg   <= '0;
        if (!dec_err && !store_none) begin
          addr_reg <= dec_idx;
        end
        if (!dec_err && bus.req_we) begin
          din_reg <= bus.req_wdata;
        end
      end
      if (state_reg == ST_WAIT) begin
        cnt_reg <= cnt_reg + 1'b1;
        if (cnt_last) begin
          if (we_reg) begin
            din_reg <= merged;
          end else begin
            rdata_reg <= ram_dout;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ctrl_reg_bridge.sv
// Randomized bench for ctrl_reg_bridge: a word-array reference model predicts every
// response, its latency and the RAM writes it should cause.
module tb_ctrl_reg_bridge;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          NW   = 16;
  localparam int          LAT  = 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn = 0;

  ctrl_reg_bridge_if bus ();

  ctrl_reg_bridge #(
    .BASE_ADDR   (BASE),
    .NUM_WORDS   (NW),
    .RAM_LATENCY (LAT)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read (latency 1).
  logic [31:0] ram [NW];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr[3:0]] <= ram_din;
    ram_dout <= ram[ram_addr[3:0]];
  end

  // Write monitor.
  int          wr_cnt = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;
  always @(posedge clk) begin
    if (ram_we) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= ram_addr;
      last_wr_data <= ram_din;
    end
  end

  // Reference model storage.
  logic [31:0] ref_mem [NW];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one request; entered and left at a negedge.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int stall, input bit hold_valid);
    logic [31:0] off;
    bit          err;
    int          idx;
    logic [31:0] exp_rdata;
    logic [31:0] exp_data;
    bit          exp_wr;
    int          exp_lat;
    int          lat;
    int          guard;
    int          wr_before;

    off       = addr - BASE;
    err       = (addr % 4 != 0) || (off >= 32'(4 * NW));
    idx       = int'(off / 4) % NW;
    exp_rdata = 32'h0;
    exp_data  = 32'h0;
    exp_wr    = 1'b0;
    if (!err) begin
      if (!we) begin
        exp_rdata = ref_mem[idx];
      end else if (wstrb != 4'h0) begin
        for (int b = 0; b < 4; b++)
          exp_data[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : ref_mem[idx][8*b +: 8];
        exp_wr = 1'b1;
      end
    end
    if (err || (we && wstrb == 4'h0)) exp_lat = 1;
    else if (!we)                     exp_lat = 2 + LAT;
    else if (wstrb == 4'hF)           exp_lat = 2;
    else                              exp_lat = 3 + LAT;

    wr_before     = wr_cnt;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wstrb = wstrb;
    bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_timeout", 32'(guard < 50), 32'd1);
    @(posedge clk);

    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && !hold_valid) bus.req_valid = 1'b0;
    end while (!bus.resp_valid && lat < 40);
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_err", 32'(bus.resp_err), 32'(err));
    check("resp_rdata", bus.resp_rdata, exp_rdata);

    if (stall > 0) begin
      bus.resp_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("stall_valid", 32'(bus.resp_valid), 32'd1);
        check("stall_rdata", bus.resp_rdata, exp_rdata);
        check("stall_err", 32'(bus.resp_err), 32'(err));
        check("stall_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.resp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("resp_done", 32'(bus.resp_valid), 32'd0);
    check("ready_idle", 32'(bus.req_ready), 32'd1);

    check("wr_count", 32'(wr_cnt - wr_before), 32'(exp_wr));
    if (exp_wr) begin
      check("wr_addr", last_wr_addr, 32'(idx));
      check("wr_data", last_wr_data, exp_data);
      ref_mem[idx] = exp_data;
    end
    n_txn++;
    $display("txn %0d: we=%0b addr=%h wdata=%h wstrb=%h -> err=%0b rdata=%h lat=%0d stall=%0d",
             n_txn, we, addr, wdata, wstrb, bus.resp_err, bus.resp_rdata, lat, stall);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  st;
    int          sel;
    int          wr_before;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_wstrb  = 4'h0;
    bus.resp_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_din", ram_din, 32'h0);
    rstn = 1'b1;
    #1;
    check("rel_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("post_rel_ready", 32'(bus.req_ready), 32'd1);

    // Fill every word through the bridge so RAM and model agree.
    for (int w = 0; w < NW; w++) do_txn(1'b1, BASE + 32'(4 * w), $urandom, 4'hF, 0, 1'b0);

    // Directed cases.
    do_txn(1'b1, 32'h8000_0008, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
    check("dir_full_data", last_wr_data, 32'hDEAD_BEEF);
    do_txn(1'b0, 32'h8000_0008, 32'h0, 4'h0, 0, 1'b0);
    do_txn(1'b1, 32'h8000_0008, 32'h1122_3344, 4'hF, 0, 1'b0);
    do_txn(1'b1, 32'h8000_0008, 32'hAABB_CCDD, 4'b0101, 0, 1'b0);
    check("dir_partial_data", last_wr_data, 32'h11BB_33DD);
    do_txn(1'b0, 32'h8000_0006, 32'h0, 4'hF, 0, 1'b0);
    do_txn(1'b1, 32'h8000_0040, 32'h1234_5678, 4'hF, 0, 1'b0);
    do_txn(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, 1'b0);
    do_txn(1'b0, 32'h8000_003C, 32'h0, 4'h0, 0, 1'b0);
    do_txn(1'b1, 32'h8000_0010, 32'h5555_AAAA, 4'h0, 0, 1'b0);

    // Backpressure with a second request already pending.
    do_txn(1'b0, 32'h8000_0008, 32'h0, 4'h3, 5, 1'b1);
    do_txn(1'b0, 32'h8000_0008, 32'h0, 4'h3, 0, 1'b0);

    // Reset during WAIT of a partial store.
    wr_before     = wr_cnt;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h8000_000C;
    bus.req_wdata = 32'hCAFE_F00D;
    bus.req_wstrb = 4'b1100;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midrst_ram_we", 32'(ram_we), 32'd0);
    check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    check("midrst_ram_addr", ram_addr, 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("midrst_ready_back", 32'(bus.req_ready), 32'd1);
    check("midrst_no_resp", 32'(bus.resp_valid), 32'd0);
    check("midrst_no_write", 32'(wr_cnt - wr_before), 32'd0);
    do_txn(1'b0, 32'h8000_000C, 32'h0, 4'h0, 0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        6:       a = BASE + 32'(4 * $urandom_range(0, NW - 1)) + 32'($urandom_range(1, 3));
        7:       a = BASE + 32'(4 * NW) + 32'(4 * $urandom_range(0, 1000));
        8:       a = BASE - 32'(4 * $urandom_range(1, 1000));
        9:       a = ($urandom_range(0, 1) == 1) ? BASE + 32'(4 * NW - 4) : BASE + 32'(4 * NW);
        default: a = BASE + 32'(4 * $urandom_range(0, NW - 1));
      endcase
      case ($urandom_range(0, 3))
        0:       st = 4'h0;
        1:       st = 4'hF;
        default: st = 4'($urandom);
      endcase
      do_txn(1'($urandom), a, $urandom, st, $urandom_range(0, 3), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ctrl_reg_bridge.md
Name: ctrl_reg_bridge

Overview:
Upstream front-end for the control-register scratch RAM (16 x 32-bit single-port BRAM, 1-cycle read latency, single write enable). Accepts core load/store requests over a valid/ready handshake and decodes and range-checks the address. Drives the RAM's we/addr/din. Performs read-modify-write for byte-strobed stores and returns one response per request.

Parameters:
BASE_ADDR, 32'h8000_0000, byte address of word 0 of the control-register window
NUM_WORDS, 16, number of 32-bit words in the window; power of two, at most 16
RAM_LATENCY, 1, clock edges from RAM address sample to valid ram_dout; at least 1

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  bridge can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data
req_wstrb  in  4  byte enables for stores (bit i = byte i); ignored for loads
resp_valid  out  1  response present
resp_ready  in  1  consumer takes the response
resp_rdata  out  32  load data; 0 for stores and errors
resp_err  out  1  misaligned or out-of-window access
ram_we  out  1  RAM write enable
ram_addr  out  32  RAM word index, zero-extended; bits [31:4] always 0
ram_din  out  32  RAM write data
ram_dout  in  32  RAM read data

Behaviour:
- Reset: clk and rstn as above; reset is asynchronous and active-low. While rstn=0: state IDLE, latency counter 0, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, ram_we=0, ram_addr=0, ram_din=0. req_ready=1 from the first edge after deassertion.
- Reset mid-operation: the in-flight request is dropped with no response. ram_we falls immediately with rstn.
- Handshake: one outstanding request at a time. req_ready=1 only in IDLE. A transfer occurs on an edge with req_valid & req_ready; all req_* fields are latched at that edge. A response transfers on an edge with resp_valid & resp_ready. resp_* stay stable while resp_valid=1 and resp_ready=0.
- Decode:
  - off = req_addr - BASE_ADDR (32-bit wrap).
  - err = (req_addr[1:0] != 0) | (off >= 4*NUM_WORDS).
  - Word index = off[$clog2(NUM_WORDS)+1:2].
- States:
  - IDLE: on accept, go to RESP if err, or if store with wstrb=0; go to WR if store with wstrb=4'hF; otherwise go to RD (load, or partial store).
  - RD: ram_addr=index, ram_we=0, for 1 cycle. Then WAIT.
  - WAIT: count RAM_LATENCY-1 further cycles. On the edge at which ram_dout is valid (RAM_LATENCY edges after the RD sample edge), capture ram_dout. For a load, resp_rdata <= ram_dout and go to RESP. For a partial store, merged <= per-byte (wstrb[i] ? wdata : ram_dout) and go to WR.
  - WR: ram_we=1, ram_addr=index, ram_din = wdata (full store) or merged (partial store), for exactly 1 cycle. Then RESP.
  - RESP: resp_valid=1. resp_err=err. resp_rdata = load data, or 0 for stores and errors. On a response transfer, go to IDLE. A new request can be accepted the cycle after.
- Latency from accept edge to resp_valid rising:
  - error or wstrb=0: 1 cycle
  - full store: 2 cycles
  - load: 2+RAM_LATENCY cycles
  - partial store: 3+RAM_LATENCY cycles
- RAM access rules:
  - ram_we=1 only in WR: one pulse per accepted non-error store with wstrb != 0.
  - Error requests and loads never write the RAM.
  - ram_addr holds its last value outside RD/WR.
- Boundary conditions:
  - Address BASE_ADDR+4*NUM_WORDS-4 is valid; BASE_ADDR+4*NUM_WORDS is an error.
  - Addresses below BASE_ADDR wrap to a large off and are errors.
  - req_wstrb is don't-care for loads.
  - req_valid may stay high through the whole sequence; the next request is accepted only when the bridge returns to IDLE.

Test Plan:
- Reset then full store addr 32'h8000_0008, wdata 32'hDEAD_BEEF, wstrb 4'hF -> 2 cycles after accept: one ram_we pulse, ram_addr=2, ram_din=32'hDEAD_BEEF; resp_valid with err=0, rdata=0.
- Load 32'h8000_0008 with RAM model returning 32'hDEAD_BEEF -> ram_we stays 0; resp_rdata=32'hDEAD_BEEF 3 cycles after accept (RAM_LATENCY=1).
- RAM word 2 = 32'h1122_3344; store wdata 32'hAABB_CCDD, wstrb 4'b0101 -> read of index 2, then ram_din=32'h11BB_33DD with one ram_we pulse; response 4 cycles after accept.
- Errors: load 32'h8000_0006 (misaligned), store 32'h8000_0040 (out of window), load 32'h7FFF_FFFC (below base) -> no RAM access, resp_err=1, rdata=0, 1 cycle after accept.
- Backpressure: resp_ready=0 for 5 cycles during a load response -> resp_valid/rdata stable, req_ready=0, and a second pending req_valid is not accepted until the response transfers.
- rstn pulsed low during WAIT of a partial store -> ram_we never asserts, no response; req_ready=1 and a fresh load completes normally after release.
